// File: rtl/setare_pkg.sv
// Shared types and default timing constants for the time/alarm setting sequencer.
package setare_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SET_TIME,
    SET_ALARM,
    COMMIT
  } state_e;

  localparam int unsigned DEF_REPEAT_DELAY_MS = 500;
  localparam int unsigned DEF_REPEAT_RATE_MS  = 100;
  localparam int unsigned DEF_TIMEOUT_MS      = 10000;
  localparam int unsigned DEF_BLINK_MS        = 500;
  localparam int unsigned DEF_CNT_W           = 14;

endpackage

// File: rtl/setare_ctrl_btn_repeat.sv
// Rising-edge detect plus delay/rate auto-repeat for one increment button.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned CNT_W           = 14
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_ms_i,
  input  logic btn_i,
  input  logic en_i,
  input  logic hold_i,
  output logic inc_o
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_MS - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_MS - 1);

  logic             btn_q;
  logic             act_q, act_d;
  logic             rep_q, rep_d;
  logic             inc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  // act_q arms the repeat counter only after a fresh rise seen while enabled
  always_comb begin
    rise  = btn_i & ~btn_q;
    act_d = act_q;
    rep_d = rep_q;
    cnt_d = cnt_q;
    inc_d = 1'b0;
    if (!en_i || hold_i || !btn_i) begin
      act_d = 1'b0;
      rep_d = 1'b0;
      cnt_d = '0;
    end else if (rise) begin
      act_d = 1'b1;
      rep_d = 1'b0;
      cnt_d = '0;
      inc_d = 1'b1;
    end else if (act_q && tick_ms_i) begin
      if (cnt_q == (rep_q ? RATE_LAST : DELAY_LAST)) begin
        cnt_d = '0;
        rep_d = 1'b1;
        inc_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_q <= 1'b1;
      act_q <= 1'b0;
      rep_q <= 1'b0;
      cnt_q <= '0;
      inc_o <= 1'b0;
    end else begin
      btn_q <= btn_i;
      act_q <= act_d;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
      inc_o <= inc_d;
    end
  end

endmodule

// File: rtl/setare_ctrl.sv
// Button sequencer for time/alarm setting: mode FSM, auto-repeat increments,
// inactivity timeout and display blink.
module setare_ctrl
  import setare_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int unsigned REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
  parameter int unsigned TIMEOUT_MS      = DEF_TIMEOUT_MS,
  parameter int unsigned BLINK_MS        = DEF_BLINK_MS,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_ms,
  input  logic btn_mode,
  input  logic btn_ok,
  input  logic btn_h,
  input  logic btn_m,
  output logic set_time,
  output logic set_alarm,
  output logic inc_hours,
  output logic inc_minutes,
  output logic stop,
  output logic aborted,
  output logic blink
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_MS - 1);

  state_e           state_q, state_d;
  logic             mode_q, ok_q;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] bl_cnt_q, bl_cnt_d;
  logic             blink_d, set_time_d, set_alarm_d, stop_d, aborted_d;
  logic             rise_mode, rise_ok, editing, state_chg, rep_en;

  always_comb begin
    rise_mode = btn_mode & ~mode_q;
    rise_ok   = btn_ok & ~ok_q;
    editing   = (state_q == SET_TIME) || (state_q == SET_ALARM);
    state_d   = state_q;
    aborted_d = 1'b0;
    to_cnt_d  = to_cnt_q;
    bl_cnt_d  = bl_cnt_q;
    blink_d   = blink_q_hold();

    if (editing) begin
      if (rise_mode || rise_ok || btn_h || btn_m) begin
        to_cnt_d = '0;
      end else if (tick_ms && to_cnt_q != '1) begin
        to_cnt_d = to_cnt_q + CNT_W'(1);
      end
      if (tick_ms) begin
        if (bl_cnt_q == BLINK_LAST) begin
          bl_cnt_d = '0;
          blink_d  = ~blink;
        end else begin
          bl_cnt_d = bl_cnt_q + CNT_W'(1);
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rise_mode) state_d = SET_TIME;
      end
      SET_TIME, SET_ALARM: begin
        if (rise_ok) begin
          state_d = COMMIT;
        end else if (rise_mode) begin
          state_d   = (state_q == SET_TIME) ? SET_ALARM : IDLE;
          aborted_d = (state_q == SET_ALARM);
        end else if (to_cnt_d == TIMEOUT_CNT) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every state change restarts the ms counters and re-evaluates blink
    state_chg = (state_d != state_q);
    if (state_chg) begin
      to_cnt_d = '0;
      bl_cnt_d = '0;
      unique case (state_d)
        SET_TIME, SET_ALARM: blink_d = 1'b1;
        COMMIT:              blink_d = blink;
        default:             blink_d = 1'b0;
      endcase
    end

    set_time_d  = (state_d == SET_TIME)  || (state_d == COMMIT && set_time);
    set_alarm_d = (state_d == SET_ALARM) || (state_d == COMMIT && set_alarm);
    stop_d      = (state_d == COMMIT);
    rep_en      = editing && !state_chg;
  end

  function automatic logic blink_q_hold();
    return blink;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 1'b1;
      ok_q      <= 1'b1;
      to_cnt_q  <= '0;
      bl_cnt_q  <= '0;
      set_time  <= 1'b0;
      set_alarm <= 1'b0;
      stop      <= 1'b0;
      aborted   <= 1'b0;
      blink     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= btn_mode;
      ok_q      <= btn_ok;
      to_cnt_q  <= to_cnt_d;
      bl_cnt_q  <= bl_cnt_d;
      set_time  <= set_time_d;
      set_alarm <= set_alarm_d;
      stop      <= stop_d;
      aborted   <= aborted_d;
      blink     <= blink_d;
    end
  end

  btn_repeat #(
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
    .REPEAT_RATE_MS (REPEAT_RATE_MS),
    .CNT_W          (CNT_W)
  ) u_rep_hours (
    .clock    (clock),
    .reset    (reset),
    .tick_ms_i(tick_ms),
    .btn_i    (btn_h),
    .en_i     (rep_en),
    .hold_i   (1'b0),
    .inc_o    (inc_hours)
  );

  // Minutes are locked out while the hours button is held
  btn_repeat #(
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
    .REPEAT_RATE_MS (REPEAT_RATE_MS),
    .CNT_W          (CNT_W)
  ) u_rep_minutes (
    .clock    (clock),
    .reset    (reset),
    .tick_ms_i(tick_ms),
    .btn_i    (btn_m),
    .en_i     (rep_en),
    .hold_i   (btn_h),
    .inc_o    (inc_minutes)
  );

endmodule

// File: tb/tb_setare_ctrl.sv
// Scenario bench for setare_ctrl; pulse outputs are matched against a queue of expected cycles.
module tb_setare_ctrl;

  logic clock = 1'b0;
  logic reset, tick_ms, btn_mode, btn_ok, btn_h, btn_m;
  logic set_time, set_alarm, inc_hours, inc_minutes, stop, aborted, blink;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_q [4][$];
  string names [4] = '{"inc_hours", "inc_minutes", "stop", "aborted"};

  setare_ctrl #(
    .REPEAT_DELAY_MS(5),
    .REPEAT_RATE_MS (2),
    .TIMEOUT_MS     (20),
    .BLINK_MS       (3),
    .CNT_W          (14)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick_ms    (tick_ms),
    .btn_mode   (btn_mode),
    .btn_ok     (btn_ok),
    .btn_h      (btn_h),
    .btn_m      (btn_m),
    .set_time   (set_time),
    .set_alarm  (set_alarm),
    .inc_hours  (inc_hours),
    .inc_minutes(inc_minutes),
    .stop       (stop),
    .aborted    (aborted),
    .blink      (blink)
  );

  always #5 clock = ~clock;

  // Advance one cycle and score every pulse output against its expected-cycle queue
  task automatic cycle();
    logic [3:0] pulses;
    int e;
    @(negedge clock);
    cyc++;
    pulses = {aborted, stop, inc_minutes, inc_hours};
    for (int k = 0; k < 4; k++) begin
      if (exp_q[k].size() > 0 && exp_q[k][0] < cyc) begin
        n_tests++;
        n_fail++;
        e = exp_q[k].pop_front();
        $display("FAIL %s missed: no pulse at cycle %0d, required one (now %0d)", names[k], e, cyc);
      end
      if (pulses[k]) begin
        n_tests++;
        if (exp_q[k].size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected: pulse at cycle %0d, required none", names[k], cyc);
        end else begin
          e = exp_q[k].pop_front();
          if (e != cyc) begin
            n_fail++;
            $display("FAIL %s timing: pulse at cycle %0d, required %0d", names[k], cyc, e);
          end
        end
      end
    end
  endtask

  task automatic tick();
    tick_ms = 1'b1;
    cycle();
    tick_ms = 1'b0;
    cycle();
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1;
    cycle();
    btn_mode = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    n_tests++;
    if ({set_time, set_alarm, inc_hours, inc_minutes, stop, aborted, blink} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {set_time, set_alarm, inc_hours, inc_minutes, stop, aborted, blink});
    end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_mode_cycling();
    pulse_mode();
    n_tests++;
    if ({set_time, set_alarm, blink} !== 3'b101) begin
      n_fail++;
      $display("FAIL mode_first: set_time/set_alarm/blink=%b, required 101", {set_time, set_alarm, blink});
    end
    pulse_mode();
    n_tests++;
    if ({set_time, set_alarm, blink} !== 3'b011) begin
      n_fail++;
      $display("FAIL mode_second: set_time/set_alarm/blink=%b, required 011", {set_time, set_alarm, blink});
    end
    exp_q[3].push_back(cyc + 1);
    pulse_mode();
    n_tests++;
    if ({set_time, set_alarm, blink} !== 3'b000) begin
      n_fail++;
      $display("FAIL mode_exit: set_time/set_alarm/blink=%b, required 000", {set_time, set_alarm, blink});
    end
  endtask

  task automatic test_commit();
    pulse_mode();
    repeat (3) tick();
    n_tests++;
    if (blink !== 1'b0) begin
      n_fail++;
      $display("FAIL blink_toggle: blink=%b after 3 ticks, required 0", blink);
    end
    btn_ok = 1'b1;
    exp_q[2].push_back(cyc + 1);
    cycle();
    n_tests++;
    if ({stop, set_time, set_alarm} !== 3'b110) begin
      n_fail++;
      $display("FAIL commit_cycle: stop/set_time/set_alarm=%b, required 110", {stop, set_time, set_alarm});
    end
    btn_ok = 1'b0;
    cycle();
    n_tests++;
    if ({stop, set_time, set_alarm, blink} !== 4'b0000) begin
      n_fail++;
      $display("FAIL commit_after: stop/set_time/set_alarm/blink=%b, required 0000",
               {stop, set_time, set_alarm, blink});
    end
  endtask

  task automatic test_auto_repeat();
    pulse_mode();
    pulse_mode();
    btn_h = 1'b1;
    exp_q[0].push_back(cyc + 1);
    cycle();
    for (int i = 1; i <= 11; i++) begin
      if (i == 5 || i == 7 || i == 9 || i == 11) exp_q[0].push_back(cyc + 1);
      tick();
    end
    btn_h = 1'b0;
    cycle();
    repeat (6) tick();
    n_tests++;
    if (set_alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_mode: set_alarm=%b, required 1", set_alarm);
    end
    exp_q[3].push_back(cyc + 1);
    pulse_mode();
  endtask

  task automatic test_priority();
    pulse_mode();
    btn_h = 1'b1;
    exp_q[0].push_back(cyc + 1);
    cycle();
    tick();
    btn_m = 1'b1;
    cycle();
    repeat (2) tick();
    btn_h = 1'b0;
    cycle();
    repeat (6) tick();
    btn_m = 1'b0;
    cycle();
    btn_m = 1'b1;
    exp_q[1].push_back(cyc + 1);
    cycle();
    btn_m = 1'b0;
    repeat (2) cycle();
    btn_ok = 1'b1;
    exp_q[2].push_back(cyc + 1);
    cycle();
    btn_ok = 1'b0;
    cycle();
  endtask

  task automatic test_timeout();
    pulse_mode();
    repeat (19) tick();
    btn_m = 1'b1;
    exp_q[1].push_back(cyc + 1);
    cycle();
    btn_m = 1'b0;
    cycle();
    repeat (19) tick();
    n_tests++;
    if (set_time !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_restart: set_time=%b after 19 ticks past btn_m, required 1", set_time);
    end
    exp_q[3].push_back(cyc + 1);
    tick();
    n_tests++;
    if ({set_time, stop, blink} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_exit: set_time/stop/blink=%b, required 000", {set_time, stop, blink});
    end
  endtask

  task automatic test_reset_mid_edit();
    pulse_mode();
    btn_h = 1'b1;
    exp_q[0].push_back(cyc + 1);
    cycle();
    tick();
    reset = 1'b1;
    repeat (2) cycle();
    n_tests++;
    if ({set_time, set_alarm, inc_hours, inc_minutes, stop, aborted, blink} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_edit: outputs=%b, required 0000000",
               {set_time, set_alarm, inc_hours, inc_minutes, stop, aborted, blink});
    end
    reset = 1'b0;
    cycle();
    repeat (6) tick();
    btn_ok = 1'b1;
    cycle();
    btn_ok = 1'b0;
    cycle();
    btn_h = 1'b0;
    cycle();
    btn_h = 1'b1;
    cycle();
    btn_h = 1'b0;
    repeat (3) cycle();
    n_tests++;
    if ({set_time, set_alarm, stop, aborted, blink} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_ignores: set_time/set_alarm/stop/aborted/blink=%b, required 00000",
               {set_time, set_alarm, stop, aborted, blink});
    end
  endtask

  initial begin
    reset    = 1'b1;
    tick_ms  = 1'b0;
    btn_mode = 1'b0;
    btn_ok   = 1'b0;
    btn_h    = 1'b0;
    btn_m    = 1'b0;
    test_reset();
    test_mode_cycling();
    test_commit();
    test_auto_repeat();
    test_priority();
    test_timeout();
    test_reset_mid_edit();
    repeat (3) cycle();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL %s drained: %0d pulses outstanding, required 0", names[k], exp_q[k].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
